// File: rtl/nbit_isqrt.sv
// Sequential restoring integer square root: one root bit per clock, N cycles per result.
// Optional round-to-nearest root output is enabled by defining NBIT_ISQRT_ROUND_EN.
module nbit_isqrt #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [2*N-1:0] radicand,
   output logic [N-1:0]   root,
   output logic [N:0]     remainder,
   output logic           done,
   output logic           busy
);

   // Handshake: start is a single-cycle request, taken only while idle (busy low);
   // done is a single-cycle pulse and root/remainder hold until the next completion.

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [0:0]    S_IDLE   = 1'b0;
   localparam logic [0:0]    S_CALC   = 1'b1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

   logic [0:0]     state_q, state_d;
   logic [2*N-1:0] rad_q, rad_d;
   logic [N-1:0]   proot_q, proot_d;
   logic [N-1:0]   prem_q, prem_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   root_q, root_d;
   logic [N:0]     rem_q, rem_d;
   logic           done_q, done_d;
   logic           busy_q, busy_d;

   logic [N+1:0]   shifted;
   logic [N+1:0]   trial;
   logic [N+1:0]   rem_work;
   logic           fit;
   logic [N-1:0]   root_fin;

   // Working remainder is N+2 bits wide so the trial compare cannot overflow.
   always_comb begin
      shifted  = {prem_q, rad_q[2*N-1 -: 2]};
      trial    = {proot_q, 2'b01};
      fit      = (shifted >= trial);
      rem_work = fit ? (shifted - trial) : shifted;
   end

`ifdef NBIT_ISQRT_ROUND_EN
   logic [N:0] root_inc;
   logic [N:0] rem_fin;
   logic [N:0] root_cmp;

   // Round up when remainder exceeds the floor root, saturating at all-ones.
   always_comb begin
      rem_fin  = (N+1)'(rem_work);
      root_cmp = {1'b0, proot_d};
      root_inc = root_cmp + 1'b1;
      root_fin = proot_d;
      if (rem_fin > root_cmp) begin
         root_fin = root_inc[N] ? {N{1'b1}} : root_inc[N-1:0];
      end
   end
`else
   always_comb begin
      root_fin = proot_d;
   end
`endif

   always_comb begin
      state_d = state_q;
      rad_d   = rad_q;
      proot_d = proot_q;
      prem_d  = prem_q;
      cnt_d   = cnt_q;
      root_d  = root_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CALC;
               rad_d   = radicand;
               proot_d = '0;
               prem_d  = '0;
               cnt_d   = CNT_LOAD;
               busy_d  = 1'b1;
            end
         end
         S_CALC: begin
            rad_d   = rad_q << 2;
            proot_d = {proot_q[N-2:0], fit};
            prem_d  = N'(rem_work);
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               root_d  = root_fin;
               rem_d   = (N+1)'(rem_work);
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rad_q   <= '0;
         proot_q <= '0;
         prem_q  <= '0;
         cnt_q   <= '0;
         root_q  <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rad_q   <= rad_d;
         proot_q <= proot_d;
         prem_q  <= prem_d;
         cnt_q   <= cnt_d;
         root_q  <= root_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign root      = root_q;
   assign remainder = rem_q;
   assign done      = done_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_nbit_isqrt.sv
// Directed bench for nbit_isqrt (N=8); root expectations follow NBIT_ISQRT_ROUND_EN when defined.
module tb_nbit_isqrt;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [15:0]  radicand = '0;
   logic [7:0]   root;
   logic [8:0]   remainder;
   logic         done;
   logic         busy;

   int checks = 0;
   int failures = 0;

   nbit_isqrt #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .radicand  (radicand),
      .root      (root),
      .remainder (remainder),
      .done      (done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_root(input int fl, input int rm);
`ifdef NBIT_ISQRT_ROUND_EN
      if (rm > fl) return (fl == 255) ? 255 : fl + 1;
      return fl;
`else
      return (rm >= 0) ? fl : fl;
`endif
   endfunction

   // Issues start now (accepted at the next edge), then waits for done with a cycle budget.
   task automatic run_op(input int value, input int fl, input int rm, input string tag);
      int lat;
      bit seen;
      radicand = 16'(value);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      radicand = 16'($urandom_range(0, 65535));
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (done === 1'b1) seen = 1'b1;
         else check({tag, "_busy_hi"}, 32'(busy), 32'd1);
      end
      check({tag, "_latency"}, 32'(lat), 32'd8);
      check({tag, "_busy_lo"}, 32'(busy), 32'd0);
      check({tag, "_root"}, 32'(root), 32'(exp_root(fl, rm)));
      check({tag, "_rem"}, 32'(remainder), 32'(rm));
   endtask

   initial begin
      int dcount;
      int dlat;
      logic [7:0] droot;
      logic [8:0] drem;

      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("idle_root", 32'(root), 32'd0);
         check("idle_rem", 32'(remainder), 32'd0);
         check("idle_done", 32'(done), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
      end

      run_op(144, 12, 0, "r144");
      @(posedge clk);
      #1;
      check("r144_done_1cyc", 32'(done), 32'd0);

      run_op(0, 0, 0, "r0");
      run_op(1, 1, 0, "r1");
      run_op(200, 14, 4, "r200");
      run_op(65535, 255, 510, "r65535");
      run_op(211, 14, 15, "r211");
      @(posedge clk);
      #1;

      // Second start arrives three cycles after the first and must be dropped.
      radicand = 16'd100;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      dcount = 0;
      dlat = 0;
      droot = '0;
      drem = '0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc == 2) begin
            radicand = 16'd49;
            start = 1'b1;
         end
         if (cyc == 3) start = 1'b0;
         if (done === 1'b1) begin
            dcount++;
            dlat = cyc;
            droot = root;
            drem = remainder;
         end
      end
      check("ignore_count", 32'(dcount), 32'd1);
      check("ignore_latency", 32'(dlat), 32'd8);
      check("ignore_root", 32'(droot), 32'(exp_root(10, 0)));
      check("ignore_rem", 32'(drem), 32'd0);

      // Abort mid-computation with reset.
      radicand = 16'd81;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_root", 32'(root), 32'd0);
      check("abort_rem", 32'(remainder), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      dcount = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) dcount++;
      end
      check("abort_no_done", 32'(dcount), 32'd0);
      check("abort_idle_busy", 32'(busy), 32'd0);
      check("abort_idle_root", 32'(root), 32'd0);
      check("abort_idle_rem", 32'(remainder), 32'd0);
      run_op(81, 9, 0, "r81_fresh");
      @(posedge clk);
      #1;

      // Squarer-chained stream: each start lands in the previous done cycle.
      for (int d = 0; d < 256; d++) begin
         run_op(d * d, d, 0, "chain");
      end
      @(posedge clk);
      #1;
      check("chain_done_1cyc", 32'(done), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
